ahb_slave_sram_32: RTL
======================

// Module: ahb_slave_sram_32
// PURPOSE
//  AHB-Lite 32-bit slave backed by a word-addressed register memory; direct downstream consumer of
//  master_ahb_32. Decodes the address/control phase driven by the master, inserts programmable wait
//  states and returns i_hrdata/i_hready/i_hresp. Flags illegal accesses with a two-cycle ERROR response.
// PARAMETERS
//  DEPTH        64           memory depth in 32-bit words (power of 2, 4..1024); ADDR_W = log2(DEPTH)
//  BASE_ADDR    32'h0000_0000 window base; aligned to DEPTH*4
//  WAIT_STATES  0            hready-low cycles inserted per OKAY NONSEQ/SEQ data phase (0..15)
// PORTS
//  i_hclk       in   1   AHB clock, all logic on rising edge
//  i_hreset     in   1   asynchronous, active-high reset
//  i_hsel       in   1   slave select from decoder
//  i_htrans     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  i_haddr      in   32  byte address
//  i_hwrite     in   1   1 write, 0 read
//  i_hsize      in   3   000 byte, 001 half, 010 word; others illegal
//  i_hburst     in   3   accepted, not used (each beat decoded independently)
//  i_hwdata     in   32  write data, valid in data phase
//  i_hmastlock  in   1   accepted, ignored
//  o_hrdata     out  32  read data, valid when o_hready=1 in read data phase
//  o_hready     out  1   transfer done / slave ready
//  o_hresp      out  2   00 OKAY, 01 ERROR
//  o_err_cnt    out  8   saturating count of ERROR responses
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): state IDLE, o_hready=1, o_hresp=00, o_hrdata=0,
//   o_err_cnt=0; all pending phase registers cleared; memory contents NOT reset.
//  Address phase accepted on a rising edge with o_hready=1 && i_hsel && i_htrans[1]; captures addr,
//   write, size. IDLE/BUSY/unselected phases get zero-wait OKAY and never touch memory.
//  Error check at acceptance: hsize>010; misaligned (half with haddr[0]=1, word with haddr[1:0]!=0);
//   haddr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]. Any error -> ERR1 without memory access.
//  FSM: IDLE -> (legal, WAIT_STATES>0) WAIT | (legal, 0) DONE-in-IDLE | (illegal) ERR1.
//   WAIT: down-counter from WAIT_STATES; o_hready=0, o_hresp=00; at count 1 -> final cycle hready=1.
//   ERR1: o_hready=0, o_hresp=01 (one cycle). ERR2: o_hready=1, o_hresp=01, o_err_cnt+1 (sat 255).
//   Final data-phase cycle (hready=1) may accept the next address phase (pipelined back-to-back).
//  Latency: OKAY transfer occupies WAIT_STATES+1 data-phase cycles; ERROR always exactly 2.
//  Write: i_hwdata sampled on the completing edge of the data phase; byte lanes from size and
//   haddr[1:0] (byte: lane addr[1:0]; half: lanes {addr[1],0}+{0,1}; word: all). Other lanes kept.
//  Read: o_hrdata is the full 32-bit word at word index haddr[ADDR_W+1:2], registered, valid on
//   the hready=1 cycle; held until next read completes. Lane selection is the master's job.
//  Hazard: read whose data phase follows a write to the same word must return the merged new data
//   (forward byte-lane-wise from the write committing on the same edge).
//  i_hsel low during an accepted pipelined phase: treated as IDLE. o_hresp never 1x.
//  Reset mid-transfer: abort immediately; a write not yet at its completing edge is not committed.
// TESTING
//  1 Reset: assert i_hreset mid-WAIT -> o_hready=1, o_hresp=00, o_hrdata=0, o_err_cnt=0 next cycle.
//  2 WAIT_STATES=0: word write 0xDEADBEEF @BASE+0x10, then read same addr back-to-back ->
//    read data phase hready=1 first cycle, o_hrdata=0xDEADBEEF (forwarding path).
//  3 WAIT_STATES=3: read @BASE+0x4 -> hready low exactly 3 cycles, then hready=1, hresp=00.
//  4 Byte write 0xAA @BASE+0x13 over word 0x11223344 @BASE+0x10 -> read 0xAA223344; half write
//    0x5566 @BASE+0x12 -> read 0x55663344.
//  5 Errors: word read @BASE+0x2, hsize=011, addr BASE+DEPTH*4 -> each hready=0/hresp=01 then
//    hready=1/hresp=01; memory unchanged; o_err_cnt=3; 260 errors -> o_err_cnt=255.
//  6 IDLE/BUSY and i_hsel=0 NONSEQ -> zero-wait OKAY, memory and o_err_cnt unchanged.

Source files
------------

// File: rtl/ahb_slave_sram_32.sv
// AHB-Lite 32-bit slave over a word-addressed register memory, with programmable
// wait states, two-cycle ERROR response and same-edge write-to-read forwarding.
module ahb_slave_sram_32 #(
  parameter int unsigned DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        i_hclk,
  input  logic        i_hreset,
  input  logic        i_hsel,
  input  logic [1:0]  i_htrans,
  input  logic [31:0] i_haddr,
  input  logic        i_hwrite,
  input  logic [2:0]  i_hsize,
  input  logic [2:0]  i_hburst,
  input  logic [31:0] i_hwdata,
  input  logic        i_hmastlock,
  output logic [31:0] o_hrdata,
  output logic        o_hready,
  output logic [1:0]  o_hresp,
  output logic [7:0]  o_err_cnt
);

  localparam int unsigned ADDR_W    = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_dp_valid;
  logic                r_dp_write;
  logic [ADDR_W-1:0]   r_dp_idx;
  logic [3:0]          r_dp_mask;
  logic                r_hready;
  logic [1:0]          r_hresp;
  logic [31:0]         r_hrdata;
  logic [7:0]          r_err_cnt;
  logic [31:0]         r_mem [DEPTH];

  logic                w_accept;
  logic                w_legal;
  logic                w_commit;
  logic [ADDR_W-1:0]   w_idx;
  logic [3:0]          w_mask;
  logic [31:0]         w_wr_word;
  logic [31:0]         w_rd_word;
  logic                w_unused;

  assign w_unused = ^{i_hburst, i_hmastlock, i_htrans[0]};

  assign w_accept = r_hready && i_hsel && i_htrans[1];
  assign w_idx    = i_haddr[ADDR_W+1:2];
  // A pending write retires on the edge that ends its hready=1 data-phase cycle.
  assign w_commit = (r_state == ST_IDLE) && r_dp_valid && r_dp_write;

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    w_mask  = 4'b1111;
    w_legal = 1'b1;
    case (i_hsize)
      3'b000:  w_mask = 4'b0001 << i_haddr[1:0];
      3'b001: begin
        w_mask = i_haddr[1] ? 4'b1100 : 4'b0011;
        if (i_haddr[0]) w_legal = 1'b0;
      end
      3'b010: if (i_haddr[1:0] != 2'b00) w_legal = 1'b0;
      default: w_legal = 1'b0;
    endcase
    if (i_haddr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]) w_legal = 1'b0;
  end

  always_comb begin
    w_wr_word = r_mem[r_dp_idx];
    for (int b = 0; b < 4; b++) begin
      if (r_dp_mask[b]) w_wr_word[8*b +: 8] = i_hwdata[8*b +: 8];
    end
  end

  // A zero-wait read accepted on the same edge a write retires sees the merged word.
  assign w_rd_word = (w_commit && (r_dp_idx == w_idx)) ? w_wr_word : r_mem[w_idx];

  // NOTE: the memory array is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge i_hclk) begin
    if (w_commit) r_mem[r_dp_idx] <= w_wr_word;
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_idx   <= '0;
      r_dp_mask  <= 4'b0000;
      r_hready   <= 1'b1;
      r_hresp    <= RESP_OKAY;
      r_hrdata   <= 32'd0;
      r_err_cnt  <= 8'd0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state  <= ST_IDLE;
            r_hready <= 1'b1;
            if (!r_dp_write) r_hrdata <= r_mem[r_dp_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          r_state  <= ST_ERR2;
          r_hready <= 1'b1;
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_hready   <= 1'b1;
          r_hresp    <= RESP_OKAY;
          r_dp_valid <= 1'b0;
          if (w_accept) begin
            if (!w_legal) begin
              r_state  <= ST_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= RESP_ERROR;
            end else begin
              r_dp_valid <= 1'b1;
              r_dp_write <= i_hwrite;
              r_dp_idx   <= w_idx;
              r_dp_mask  <= w_mask;
              if (WAIT_STATES > 0) begin
                r_state  <= ST_WAIT;
                r_cnt    <= WAIT_INIT;
                r_hready <= 1'b0;
              end else if (!i_hwrite) begin
                r_hrdata <= w_rd_word;
              end
            end
          end
        end
      endcase
    end
  end

  assign o_hrdata  = r_hrdata;
  assign o_hready  = r_hready;
  assign o_hresp   = r_hresp;
  assign o_err_cnt = r_err_cnt;

endmodule
